// File: rtl/memory_bus_arbiter_pkg.sv
// Shared types and helpers for the byte-serial memory bus arbiter.
package memory_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    LOAD   = 2'd2,
    STORE  = 2'd3
  } state_t;

  // Access size codes as presented by the load/store buffer
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Memory-mapped IO page (UART) selected by address bits [IO_HI:IO_LO]
  localparam logic [1:0] IO_PAGE = 2'b11;
  localparam int         IO_HI   = 17;
  localparam int         IO_LO   = 16;

  // Byte counters run 0..4
  localparam int CNT_W = 3;

  // Number of bus bytes for an access size; the illegal code 3 acts as a word
  function automatic logic [CNT_W-1:0] len_from_size(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      SZ_W:    return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/memory_bus_arbiter_byte_assembler.sv
// Collects read bytes little-endian into a 32-bit word and tracks the next
// byte lane to fill. word_merged already contains the byte being captured,
// so the completing edge can register the full result directly.
module memory_bus_arbiter_byte_assembler
  import memory_bus_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             capture,
  input  logic [7:0]       byte_in,
  output logic [CNT_W-1:0] recv_idx,
  output logic [31:0]      word_merged
);

  logic [31:0]      word_reg;
  logic [CNT_W-1:0] recv_idx_reg;

  // Each lane takes the incoming byte when it is the one being collected
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign word_merged[8*gi +: 8] =
        (capture && (recv_idx_reg == CNT_W'(gi))) ? byte_in : word_reg[8*gi +: 8];
    end
  endgenerate

  // Clear zero-fills unused lanes so short loads come out zero-extended
  always_ff @(posedge clk) begin
    if (rst) begin
      word_reg     <= '0;
      recv_idx_reg <= '0;
    end else if (clear) begin
      word_reg     <= '0;
      recv_idx_reg <= '0;
    end else if (capture) begin
      word_reg     <= word_merged;
      recv_idx_reg <= recv_idx_reg + 3'd1;
    end
  end

  assign recv_idx = recv_idx_reg;

endmodule

// File: rtl/memory_bus_arbiter.sv
// Shares the byte-serial external memory bus between the instruction cache
// and the load/store buffer, splitting each access into byte transactions.
module memory_bus_arbiter
  import memory_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int FETCH_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  input  logic              flush,
  input  logic              icache_req,
  input  logic [ADDR_W-1:0] icache_addr,
  output logic              icache_valid,
  output logic [31:0]       icache_data,
  input  logic              lsb_req,
  input  logic              lsb_wr,
  input  logic [1:0]        lsb_size,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [31:0]       lsb_wdata,
  output logic              lsb_valid,
  output logic [31:0]       lsb_rdata
);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  issue_idx_reg, issue_idx_next;
  logic [CNT_W-1:0]  len_reg, len_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [ADDR_W-1:0] mem_a_reg, mem_a_next;
  logic [7:0]        mem_dout_reg, mem_dout_next;
  logic              wr_reg, wr_next;
  logic              icache_valid_reg, icache_valid_next;
  logic              lsb_valid_reg, lsb_valid_next;
  logic [31:0]       icache_data_reg, icache_data_next;
  logic [31:0]       lsb_rdata_reg, lsb_rdata_next;
  logic              frozen_reg;

  logic              asm_clear, asm_capture;
  logic [CNT_W-1:0]  recv_idx;
  logic [31:0]       word_merged;

  logic              io_store, store_ok, load_ok, fetch_ok;

  assign io_store = (lsb_addr[IO_HI:IO_LO] == IO_PAGE);
  // Stores are committed work and survive a flush; speculative reads do not
  assign store_ok = lsb_req && lsb_wr && !(io_store && io_buffer_full);
  assign load_ok  = lsb_req && !lsb_wr && !flush;
  assign fetch_ok = icache_req && !flush;

  memory_bus_arbiter_byte_assembler u_asm (
    .clk         (clk),
    .rst         (rst),
    .clear       (asm_clear & rdy),
    .capture     (asm_capture & rdy),
    .byte_in     (mem_din),
    .recv_idx    (recv_idx),
    .word_merged (word_merged)
  );

  // Remembers that the previous edge was frozen so the read in flight is redone
  always_ff @(posedge clk) begin
    if (rst) frozen_reg <= 1'b0;
    else     frozen_reg <= !rdy;
  end

  // State and bus registers; everything holds while rdy is low
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      issue_idx_reg    <= '0;
      len_reg          <= '0;
      addr_reg         <= '0;
      wdata_reg        <= '0;
      mem_a_reg        <= '0;
      mem_dout_reg     <= '0;
      wr_reg           <= 1'b0;
      icache_valid_reg <= 1'b0;
      lsb_valid_reg    <= 1'b0;
      icache_data_reg  <= '0;
      lsb_rdata_reg    <= '0;
    end else if (rdy) begin
      state_reg        <= state_next;
      issue_idx_reg    <= issue_idx_next;
      len_reg          <= len_next;
      addr_reg         <= addr_next;
      wdata_reg        <= wdata_next;
      mem_a_reg        <= mem_a_next;
      mem_dout_reg     <= mem_dout_next;
      wr_reg           <= wr_next;
      icache_valid_reg <= icache_valid_next;
      lsb_valid_reg    <= lsb_valid_next;
      icache_data_reg  <= icache_data_next;
      lsb_rdata_reg    <= lsb_rdata_next;
    end
  end

  // Arbitration and byte sequencing
  always_comb begin
    state_next        = state_reg;
    issue_idx_next    = issue_idx_reg;
    len_next          = len_reg;
    addr_next         = addr_reg;
    wdata_next        = wdata_reg;
    mem_a_next        = mem_a_reg;
    mem_dout_next     = mem_dout_reg;
    wr_next           = wr_reg;
    icache_valid_next = 1'b0;
    lsb_valid_next    = 1'b0;
    icache_data_next  = icache_data_reg;
    lsb_rdata_next    = lsb_rdata_reg;
    asm_clear         = 1'b0;
    asm_capture       = 1'b0;

    case (state_reg)
      IDLE: begin
        mem_a_next     = '0;
        wr_next        = 1'b0;
        issue_idx_next = '0;
        if (store_ok) begin
          state_next     = STORE;
          len_next       = io_store ? 3'd1 : len_from_size(lsb_size);
          addr_next      = lsb_addr;
          wdata_next     = lsb_wdata;
          mem_a_next     = lsb_addr;
          mem_dout_next  = lsb_wdata[7:0];
          wr_next        = 1'b1;
          issue_idx_next = 3'd1;
        end else if (load_ok) begin
          state_next     = LOAD;
          len_next       = len_from_size(lsb_size);
          addr_next      = lsb_addr;
          mem_a_next     = lsb_addr;
          issue_idx_next = 3'd1;
          asm_clear      = 1'b1;
        end else if (fetch_ok) begin
          state_next     = IFETCH;
          len_next       = CNT_W'(FETCH_BYTES);
          addr_next      = icache_addr;
          mem_a_next     = icache_addr;
          issue_idx_next = 3'd1;
          asm_clear      = 1'b1;
        end
      end

      IFETCH, LOAD: begin
        if (flush) begin
          state_next     = IDLE;
          mem_a_next     = '0;
          issue_idx_next = '0;
          asm_clear      = 1'b1;
        end else if (frozen_reg) begin
          // Byte on mem_din may belong to a stale address: re-address it
          mem_a_next     = addr_reg + ADDR_W'(recv_idx);
          issue_idx_next = recv_idx + 3'd1;
        end else begin
          asm_capture = 1'b1;
          if (recv_idx == len_reg - 3'd1) begin
            state_next     = IDLE;
            mem_a_next     = '0;
            issue_idx_next = '0;
            asm_clear      = 1'b1;
            if (state_reg == IFETCH) begin
              icache_valid_next = 1'b1;
              icache_data_next  = word_merged;
            end else begin
              lsb_valid_next = 1'b1;
              lsb_rdata_next = word_merged;
            end
          end else if (issue_idx_reg < len_reg) begin
            mem_a_next     = addr_reg + ADDR_W'(issue_idx_reg);
            issue_idx_next = issue_idx_reg + 3'd1;
          end
        end
      end

      STORE: begin
        if (issue_idx_reg < len_reg) begin
          mem_a_next     = addr_reg + ADDR_W'(issue_idx_reg);
          mem_dout_next  = wdata_reg[{issue_idx_reg[1:0], 3'b000} +: 8];
          wr_next        = 1'b1;
          issue_idx_next = issue_idx_reg + 3'd1;
        end else begin
          state_next     = IDLE;
          mem_a_next     = '0;
          wr_next        = 1'b0;
          issue_idx_next = '0;
          lsb_valid_next = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign mem_a        = mem_a_reg;
  assign mem_dout     = mem_dout_reg;
  // Masking with rdy keeps a frozen write from repeating on the bus
  assign mem_wr       = wr_reg & rdy;
  assign icache_valid = icache_valid_reg;
  assign icache_data  = icache_data_reg;
  assign lsb_valid    = lsb_valid_reg;
  assign lsb_rdata    = lsb_rdata_reg;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter with a queue-based scoreboard.
module tb_memory_bus_arbiter;

  localparam int K_IF  = 0;
  localparam int K_LSB = 1;
  localparam int K_WR  = 2;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    bit          chk_data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        flush;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_valid;
  logic [31:0] icache_data;
  logic        lsb_req;
  logic        lsb_wr;
  logic [1:0]  lsb_size;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic        lsb_valid;
  logic [31:0] lsb_rdata;

  logic [7:0]  ram [0:65535];
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  memory_bus_arbiter #(.ADDR_W(32), .FETCH_BYTES(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full),
    .flush          (flush),
    .icache_req     (icache_req),
    .icache_addr    (icache_addr),
    .icache_valid   (icache_valid),
    .icache_data    (icache_data),
    .lsb_req        (lsb_req),
    .lsb_wr         (lsb_wr),
    .lsb_size       (lsb_size),
    .lsb_addr       (lsb_addr),
    .lsb_wdata      (lsb_wdata),
    .lsb_valid      (lsb_valid),
    .lsb_rdata      (lsb_rdata)
  );

  // RAM model: read data follows the presented address within the cycle
  assign mem_din = ram[mem_a[15:0]];

  always @(posedge clk) begin
    if (mem_wr && mem_a[17:16] != 2'b11) ram[mem_a[15:0]] = mem_dout;
  end

  task automatic push(input int kind, input logic [31:0] addr,
                      input logic [31:0] data, input bit chk_data);
    exp_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.chk_data = chk_data;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Monitor side: pop the oldest expectation for every DUT output event
  task automatic mon_event(input int kind, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: kind %0d addr 0x%08h data 0x%08h, nothing expected",
               kind, addr, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == K_WR && e.addr !== addr) || (e.chk_data && e.data !== data)) begin
        errors++;
        $display("FAIL scoreboard: got kind %0d addr 0x%08h data 0x%08h, expected kind %0d addr 0x%08h data 0x%08h",
                 kind, addr, data, e.kind, e.addr, e.data);
      end else begin
        $display("txn ok: kind %0d addr 0x%08h data 0x%08h", kind, addr, data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (icache_valid && lsb_valid) begin
        checks++;
        errors++;
        $display("FAIL both_valid: icache_valid=1 lsb_valid=1, required not both");
      end
      if (icache_valid) mon_event(K_IF, 32'h0, icache_data);
      if (lsb_valid)    mon_event(K_LSB, 32'h0, lsb_rdata);
      if (mem_wr)       mon_event(K_WR, mem_a, {24'h0, mem_dout});
    end
  end

  // Wait (bounded) for a valid pulse, counting bus write cycles on the way
  task automatic wait_valid(input bit lsb_side, input string name, output int wr_cnt);
    bit seen;
    wr_cnt = 0;
    seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (mem_wr) wr_cnt++;
      if (lsb_side ? lsb_valid : icache_valid) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: valid pulse absent after 40 cycles, required present", name);
    end
  endtask

  task automatic lsb_issue(input logic wr, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata);
    lsb_req = 1'b1; lsb_wr = wr; lsb_size = size; lsb_addr = addr; lsb_wdata = wdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wr_cnt;
    int vcnt;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h1000] = 8'h13; ram[16'h1001] = 8'h05; ram[16'h1002] = 8'h00; ram[16'h1003] = 8'h00;
    ram[16'h2000] = 8'h78; ram[16'h2001] = 8'h56; ram[16'h2002] = 8'h34; ram[16'h2003] = 8'h12;
    ram[16'h1100] = 8'h93; ram[16'h1101] = 8'h00; ram[16'h1102] = 8'h10; ram[16'h1103] = 8'h00;

    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; flush = 1'b0;
    icache_req = 1'b0; icache_addr = '0;
    lsb_req = 1'b0; lsb_wr = 1'b0; lsb_size = 2'd0; lsb_addr = '0; lsb_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_a", mem_a, 32'h0);
    chk("reset_mem_wr", {31'h0, mem_wr}, 32'h0);
    chk("reset_mem_dout", {24'h0, mem_dout}, 32'h0);
    chk("reset_valids", {30'h0, icache_valid, lsb_valid}, 32'h0);
    chk("reset_icache_data", icache_data, 32'h0);
    chk("reset_lsb_rdata", lsb_rdata, 32'h0);
    rst = 1'b0;

    // Word fetch with address trace
    push(K_IF, 32'h0, 32'h0000_0513, 1'b1);
    icache_req = 1'b1; icache_addr = 32'h1000;
    @(negedge clk);
    chk("fetch_a0", mem_a, 32'h1000);
    chk("fetch_rd", {31'h0, mem_wr}, 32'h0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("fetch_addr_seq", mem_a, 32'h1000 + 32'(i));
    end
    @(negedge clk);
    chk("fetch_valid", {31'h0, icache_valid}, 32'h1);
    chk("fetch_idle_bus", mem_a, 32'h0);
    icache_req = 1'b0;
    @(negedge clk);
    chk("fetch_pulse_len", {31'h0, icache_valid}, 32'h0);

    // Contention: load wins, fetch starts at the edge after the pulse
    push(K_LSB, 32'h0, 32'h1234_5678, 1'b1);
    push(K_IF, 32'h0, 32'h0000_0513, 1'b1);
    lsb_issue(1'b0, 2'd2, 32'h2000, 32'h0);
    icache_req = 1'b1; icache_addr = 32'h1000;
    wait_valid(1'b1, "contend_load", wr_cnt);
    lsb_req = 1'b0;
    @(negedge clk);
    chk("contend_fetch_start", mem_a, 32'h1000);
    wait_valid(1'b0, "contend_fetch", wr_cnt);
    icache_req = 1'b0;
    @(negedge clk);

    // Store half then load it back (upper half must be zero)
    push(K_WR, 32'h0FFE, 32'hDD, 1'b1);
    push(K_WR, 32'h0FFF, 32'hCC, 1'b1);
    push(K_LSB, 32'h0, 32'h0, 1'b0);
    lsb_issue(1'b1, 2'd1, 32'h0FFE, 32'hAABB_CCDD);
    wait_valid(1'b1, "store_half", wr_cnt);
    lsb_req = 1'b0;
    chk("store_half_wr_cycles", 32'(wr_cnt), 32'd2);
    @(negedge clk);
    push(K_LSB, 32'h0, 32'h0000_CCDD, 1'b1);
    lsb_issue(1'b0, 2'd1, 32'h0FFE, 32'h0);
    wait_valid(1'b1, "load_half", wr_cnt);
    lsb_req = 1'b0;
    @(negedge clk);

    // IO store held off by a full UART buffer
    io_buffer_full = 1'b1;
    lsb_issue(1'b1, 2'd0, 32'h0003_0000, 32'hFFFF_FF41);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("io_blocked_wr", {31'h0, mem_wr}, 32'h0);
    end
    io_buffer_full = 1'b0;
    push(K_WR, 32'h0003_0000, 32'h41, 1'b1);
    push(K_LSB, 32'h0, 32'h0, 1'b0);
    wait_valid(1'b1, "io_store", wr_cnt);
    lsb_req = 1'b0;
    chk("io_store_wr_cycles", 32'(wr_cnt), 32'd1);
    @(negedge clk);

    // Flush aborts a load at E2
    lsb_issue(1'b0, 2'd2, 32'h2000, 32'h0);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_bus_idle", mem_a, 32'h0);
    flush = 1'b0; lsb_req = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (lsb_valid) vcnt++;
    end
    chk("flush_no_valid", 32'(vcnt), 32'd0);

    // Store accepted under flush completes every byte
    push(K_WR, 32'h0200, 32'h11, 1'b1);
    push(K_WR, 32'h0201, 32'h22, 1'b1);
    push(K_WR, 32'h0202, 32'h33, 1'b1);
    push(K_WR, 32'h0203, 32'h44, 1'b1);
    push(K_LSB, 32'h0, 32'h0, 1'b0);
    flush = 1'b1;
    lsb_issue(1'b1, 2'd2, 32'h0200, 32'h4433_2211);
    @(negedge clk);
    chk("flush_store_wr0", {31'h0, mem_wr}, 32'h1);
    @(negedge clk);
    flush = 1'b0;
    wait_valid(1'b1, "flush_store", wr_cnt);
    lsb_req = 1'b0;
    chk("flush_store_wr_rest", 32'(wr_cnt), 32'd2);
    @(negedge clk);
    push(K_LSB, 32'h0, 32'h4433_2211, 1'b1);
    lsb_issue(1'b0, 2'd2, 32'h0200, 32'h0);
    wait_valid(1'b1, "load_back", wr_cnt);
    lsb_req = 1'b0;
    @(negedge clk);

    // rdy low for two edges starting at E2 of a fetch
    push(K_IF, 32'h0, 32'h0010_0093, 1'b1);
    icache_req = 1'b1; icache_addr = 32'h1100;
    @(negedge clk);
    @(negedge clk);
    rdy = 1'b0;
    @(negedge clk);
    chk("freeze_wr", {31'h0, mem_wr}, 32'h0);
    @(negedge clk);
    chk("freeze_wr", {31'h0, mem_wr}, 32'h0);
    rdy = 1'b1;
    @(negedge clk);
    chk("resume_readdress", mem_a, 32'h1101);
    wait_valid(1'b0, "rdy_fetch", wr_cnt);
    icache_req = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (icache_valid) vcnt++;
    end
    chk("rdy_no_extra_valid", 32'(vcnt), 32'd0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
